// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the uart_tx byte-sink arbiter.
package uart_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W      = 16;

    // Next round-robin index; explicit wrap because n need not be a power of 2.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and sink-side handshake bundle for the arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF
);
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_last;
    logic [NUM_REQ-1:0]         req_ready;
    logic [DATA_W-1:0]          byte_out_data;
    logic                       byte_out_valid;
    logic                       byte_out_ready;
    logic [NUM_REQ-1:0]         grant;
    logic                       stall_err;
    logic [$clog2(NUM_REQ)-1:0] stall_id;

    // Environment side: requesters plus the uart_tx sink.
    modport master (
        output req_data, req_valid, req_last, byte_out_ready,
        input  req_ready, byte_out_data, byte_out_valid, grant, stall_err, stall_id
    );

    // Arbiter side.
    modport slave (
        input  req_data, req_valid, req_last, byte_out_ready,
        output req_ready, byte_out_data, byte_out_valid, grant, stall_err, stall_id
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority picker: first set request at or above
// start, wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         found
);
    int j;

    // Scan upward from start; the first hit wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found     = 1'b1;
                onehot[j] = 1'b1;
                idx       = W'(j);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter in front of uart_tx with a stall watchdog
// that frees the transmitter if the owner goes silent mid-packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int STALL_TIMEOUT = 1000,
    parameter int DATA_W        = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e         state, state_nx;
    logic [NUM_REQ-1:0] grant_q;
    logic [PTR_W-1:0]   owner, rr_ptr, stall_id_q, next_ptr;
    logic [CNT_W-1:0]   stall_cnt;
    logic               stall_err_q;

    logic [NUM_REQ-1:0] pick_oh;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;
    logic               owner_valid, owner_last, expire, xfer;

    rr_pick #(.N(NUM_REQ), .W(PTR_W)) u_pick (
        .req    (bus.req_valid),
        .start  (rr_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    assign owner_valid = bus.req_valid[owner];
    assign owner_last  = bus.req_last[owner];
    // Expiry outranks a late valid from the owner: nothing moves that cycle.
    assign expire      = (state == LOCK) && (stall_cnt == CNT_W'(STALL_TIMEOUT));
    assign xfer        = (state == LOCK) && !expire && owner_valid && bus.byte_out_ready;
    assign next_ptr    = PTR_W'(rr_next(int'(owner), NUM_REQ));

    assign bus.grant     = grant_q;
    assign bus.stall_err = stall_err_q;
    assign bus.stall_id  = stall_id_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and the combinational owner-to-sink pass-through.
    always_comb begin
        state_nx           = state;
        bus.req_ready      = '0;
        bus.byte_out_valid = 1'b0;
        bus.byte_out_data  = '0;
        case (state)
            IDLE: begin
                if (pick_found) state_nx = LOCK;
            end
            LOCK: begin
                bus.byte_out_data = bus.req_data[int'(owner)*DATA_W +: DATA_W];
                if (!expire) begin
                    bus.byte_out_valid = owner_valid;
                    bus.req_ready[owner] = bus.byte_out_ready;
                end
                if (expire || (xfer && owner_last)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grant, round-robin pointer and watchdog bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q     <= '0;
            owner       <= '0;
            rr_ptr      <= '0;
            stall_cnt   <= '0;
            stall_err_q <= 1'b0;
            stall_id_q  <= '0;
        end else begin
            stall_err_q <= 1'b0;
            if (state == IDLE) begin
                if (pick_found) begin
                    grant_q   <= pick_oh;
                    owner     <= pick_idx;
                    stall_cnt <= '0;
                end
            end else if (expire) begin
                grant_q     <= '0;
                rr_ptr      <= next_ptr;
                stall_cnt   <= '0;
                stall_err_q <= 1'b1;
                stall_id_q  <= owner;
            end else if (xfer && owner_last) begin
                grant_q   <= '0;
                rr_ptr    <= next_ptr;
                stall_cnt <= '0;
            end else if (owner_valid) begin
                // Valid owner, stalled or not by the sink, is never idle.
                stall_cnt <= '0;
            end else if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: queue-driven requesters, a packet-level reference model
// compared every cycle, and directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int TO = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(.NUM_REQ(N), .STALL_TIMEOUT(TO), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nchk = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: owner / pointer / quiet-cycle count
    typedef struct packed {
        int   owner;   // -1 when nobody holds the transmitter
        int   ptr;
        int   quiet;   // consecutive owner-idle cycles inside a packet
        logic err;
        int   sid;
    } mst_t;

    mst_t m;

    function automatic mst_t mnext(input mst_t s, input logic [N-1:0] v,
                                   input logic [N-1:0] l, input logic rdy);
        mst_t n;
        n = s;
        n.err = 1'b0;
        if (s.owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (n.owner < 0 && v[(s.ptr + k) % N]) begin
                    n.owner = (s.ptr + k) % N;
                    n.quiet = 0;
                end
            end
        end else if (s.quiet == TO) begin
            n.err   = 1'b1;
            n.sid   = s.owner;
            n.ptr   = (s.owner + 1) % N;
            n.owner = -1;
            n.quiet = 0;
        end else if (v[s.owner]) begin
            n.quiet = 0;
            if (rdy && l[s.owner]) begin
                n.owner = -1;
                n.ptr   = (s.owner + 1) % N;
            end
        end else begin
            n.quiet = s.quiet + 1;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{owner: -1, ptr: 0, quiet: 0, err: 1'b0, sid: 0};
        else        m <= mnext(m, bus.req_valid, bus.req_last, bus.byte_out_ready);
    end

    logic [N-1:0] e_grant, e_rdy;
    logic         e_bov, e_exp;

    // Every-cycle comparison of the DUT against the model.
    initial forever begin
        @(negedge clk);
        if (rst_n && chk_en) begin
            e_grant = '0; e_rdy = '0; e_bov = 1'b0; e_exp = 1'b0;
            if (m.owner >= 0) begin
                e_exp   = (m.quiet == TO);
                e_grant[m.owner] = 1'b1;
                e_bov   = !e_exp && bus.req_valid[m.owner];
                if (!e_exp && bus.byte_out_ready) e_rdy[m.owner] = 1'b1;
                chk("byte_out_data", bus.byte_out_data, bus.req_data[m.owner*DW +: DW]);
            end
            chk("grant", bus.grant, e_grant);
            chk("req_ready", bus.req_ready, e_rdy);
            chk("byte_out_valid", bus.byte_out_valid, e_bov);
            chk("stall_err", bus.stall_err, m.err);
            chk("stall_id", bus.stall_id, m.sid);
        end
    end

    // ---------------- requester driver: entry = data | last<<8 | gap<<16
    int           q[N][$];
    int           wcnt[N];
    int           rdy_mode;   // 0 random, 1 always ready, 2 never ready
    int           cyc;
    int           log_d[$], log_c[$], log_r[$];
    logic [N-1:0] ghist[$];
    logic         shist[$];
    int           idhist[$];

    function automatic int ent(input int d, input int last, input int gap);
        return (d & 8'hFF) | (last << 8) | (gap << 16);
    endfunction

    task automatic drive();
        logic [N*DW-1:0] d;
        logic [N-1:0]    v, l;
        int              e;
        d = '0; v = '0; l = '0;
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0 && wcnt[i] >= (q[i][0] >> 16)) begin
                e = q[i][0];
                v[i] = 1'b1;
                l[i] = e[8];
                d[i*DW +: DW] = e[7:0];
            end
        end
        bus.req_data  = d;
        bus.req_valid = v;
        bus.req_last  = l;
        case (rdy_mode)
            0:       bus.byte_out_ready = ($urandom_range(0, 9) < 7);
            1:       bus.byte_out_ready = 1'b1;
            default: bus.byte_out_ready = 1'b0;
        endcase
    endtask

    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = bus.req_valid & bus.req_ready;
        ghist.push_back(bus.grant);
        shist.push_back(bus.stall_err);
        idhist.push_back(int'(bus.stall_id));
        for (int i = 0; i < N; i++) begin
            if (acc[i] && bus.byte_out_valid) begin
                log_d.push_back(int'(bus.byte_out_data));
                log_r.push_back(i);
                log_c.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                void'(q[i].pop_front());
                wcnt[i] = 0;
            end else if (q[i].size() > 0 && !bus.req_valid[i]) begin
                wcnt[i]++;
            end
        end
        cyc++;
        drive();
    endtask

    function automatic bit busy();
        for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            wcnt[i] = 0;
        end
    endtask

    task automatic start_test();
        log_d.delete(); log_c.delete(); log_r.delete();
        ghist.delete(); shist.delete(); idhist.delete();
        cyc = 0;
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        drive();
    endtask

    task automatic run(input string name, input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            tick();
            n++;
        end
        chk(name, busy(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        clear_q();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int sum, total;

    initial begin
        // ---- reset state
        rdy_mode = 1;
        clear_q();
        drive();
        #12;
        chk("reset grant", bus.grant, 0);
        chk("reset req_ready", bus.req_ready, 0);
        chk("reset byte_out_valid", bus.byte_out_valid, 0);
        chk("reset byte_out_data", bus.byte_out_data, 0);
        chk("reset stall_err", bus.stall_err, 0);
        chk("reset stall_id", bus.stall_id, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        // ---- single requester, three-byte packet
        q[0].push_back(ent(8'h41, 0, 0));
        q[0].push_back(ent(8'h42, 0, 0));
        q[0].push_back(ent(8'h43, 1, 0));
        start_test();
        repeat (6) tick();
        chk("single grant idle", ghist[0], 4'b0000);
        chk("single grant", ghist[1], 4'b0001);
        chk("single count", log_d.size(), 3);
        for (int k = 0; k < 3 && k < log_d.size(); k++) begin
            chk("single data", log_d[k], 8'h41 + k);
            chk("single cycle", log_c[k], 1 + k);
        end
        chk("single release", ghist[4], 4'b0000);

        // ---- round robin, two passes
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) do_reset();
            for (int i = 0; i < N; i++) q[i].push_back(ent(8'hA0 + i, 1, 0));
            start_test();
            run("rr timeout", 50);
            chk("rr count", log_d.size(), 4);
            for (int k = 0; k < 4 && k < log_d.size(); k++) begin
                chk("rr data", log_d[k], 8'hA0 + k);
                chk("rr cycle", log_c[k], 1 + 2 * k);
            end
        end

        // ---- packet lock: req1 packet while req0/req2 wait, pointer at 1
        do_reset();
        q[0].push_back(ent(8'h10, 1, 0));
        start_test();
        run("lock pre timeout", 20);
        q[1].push_back(ent(8'hB0, 0, 0));
        q[1].push_back(ent(8'hB1, 0, 0));
        q[1].push_back(ent(8'hB2, 1, 0));
        q[0].push_back(ent(8'hC0, 1, 0));
        q[2].push_back(ent(8'hC2, 1, 0));
        start_test();
        run("lock timeout", 50);
        chk("lock count", log_d.size(), 5);
        if (log_d.size() == 5) begin
            chk("lock d0", log_d[0], 8'hB0);
            chk("lock d1", log_d[1], 8'hB1);
            chk("lock d2", log_d[2], 8'hB2);
            chk("lock next req", log_r[3], 2);
            chk("lock next data", log_d[3], 8'hC2);
            chk("lock last req", log_r[4], 0);
            chk("lock next cycle", log_c[3], 5);
        end

        // ---- backpressure is never a stall
        do_reset();
        q[0].push_back(ent(8'h55, 0, 0));
        q[0].push_back(ent(8'h66, 1, 0));
        start_test();
        tick();
        tick();
        rdy_mode = 2;
        drive();
        repeat (5000) tick();
        rdy_mode = 1;
        drive();
        tick();
        tick();
        sum = 0;
        foreach (shist[k]) sum += int'(shist[k]);
        chk("bp stall_err count", sum, 0);
        chk("bp grant held", ghist[5001], 4'b0001);
        chk("bp count", log_d.size(), 2);
        if (log_d.size() == 2) begin
            chk("bp data", log_d[1], 8'h66);
            chk("bp cycle", log_c[1], 5002);
        end

        // ---- stall watchdog on req3, req0 waiting
        do_reset();
        q[3].push_back(ent(8'h77, 0, 0));
        q[0].push_back(ent(8'h11, 1, 2));
        start_test();
        run("stall timeout", 100);
        tick();
        tick();
        sum = 0;
        foreach (shist[k]) sum += int'(shist[k]);
        chk("stall pulse count", sum, 1);
        chk("stall pulse", shist[13], 1'b1);
        chk("stall id", idhist[13], 3);
        chk("stall grant before", ghist[12], 4'b1000);
        chk("stall grant released", ghist[13], 4'b0000);
        chk("stall regrant", ghist[14], 4'b0001);
        chk("stall next cycle", log_c.size() == 2 ? log_c[1] : -1, 14);

        // ---- asynchronous reset mid-packet
        do_reset();
        q[1].push_back(ent(8'h20, 1, 0));
        start_test();
        run("async pre timeout", 20);
        q[2].push_back(ent(8'h30, 0, 0));
        q[2].push_back(ent(8'h31, 0, 0));
        q[2].push_back(ent(8'h32, 1, 0));
        start_test();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async grant", bus.grant, 0);
        chk("async req_ready", bus.req_ready, 0);
        chk("async byte_out_valid", bus.byte_out_valid, 0);
        clear_q();
        drive();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) q[i].push_back(ent(8'hD0 + i, 1, 0));
        start_test();
        run("async post timeout", 50);
        chk("async restart req", log_r.size() > 0 ? log_r[0] : -1, 0);
        chk("async restart data", log_d.size() > 0 ? log_d[0] : -1, 8'hD0);

        // ---- randomized traffic with random backpressure and long gaps
        do_reset();
        rdy_mode = 0;
        total = 0;
        for (int i = 0; i < N; i++) begin
            int npk, len, gap;
            npk = $urandom_range(3, 8);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    gap = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(8, 14);
                    q[i].push_back(ent($urandom_range(0, 255), (b == len - 1) ? 1 : 0, gap));
                    total++;
                end
            end
        end
        start_test();
        run("random timeout", 20000);
        chk("random byte count", log_d.size(), total);
        rdy_mode = 1;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global time limit: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx byte sink among NUM_REQ independent byte-stream requesters (debug agents, loopback, status reporters).
- Round-robin arbitration with packet lock. Once granted, a requester owns the transmitter until it transfers a byte with last=1.
- A stall watchdog forcibly releases the lock if the owner goes silent mid-packet, so one hung agent cannot block the UART.
- Sits between the requesters and uart_tx.byte_in_*, in the clk_100 domain.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- STALL_TIMEOUT, 1000, cycles of owner valid=0 mid-packet before forced release; legal range 1..65535.
- DATA_W, 8, byte width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
- req_valid  in  NUM_REQ  per-requester valid
- req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by valid
- req_ready  out  NUM_REQ  per-requester ready
- byte_out_data  out  DATA_W  to uart_tx byte_in_data
- byte_out_valid  out  1  to uart_tx byte_in_valid
- byte_out_ready  in  1  from uart_tx byte_in_ready
- grant  out  NUM_REQ  one-hot current owner; all zero when idle
- stall_err  out  1  one-cycle pulse on watchdog release
- stall_id  out  $clog2(NUM_REQ)  index of the requester released by the last watchdog event; holds its value

Behaviour:
- Reset (rst_n=0, async): state=IDLE; grant=0; req_ready=0; byte_out_valid=0; byte_out_data=0; stall_err=0; stall_id=0; rr_ptr=0; stall counter=0.
- State IDLE:
  - all req_ready=0; byte_out_valid=0.
  - If any req_valid is set, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register the winner into grant and go to LOCK.
  - Arbitration latency is exactly 1 cycle from valid seen to grant.
- State LOCK, owner g:
  - byte_out_data=req_data[g]; byte_out_valid=req_valid[g]; req_ready[g]=byte_out_ready; all other req_ready=0.
  - The path is combinational pass-through: zero added latency and no buffering.
  - Transfer = req_valid[g] & byte_out_ready.
  - Transfer with req_last[g]=1: next state IDLE, grant=0, rr_ptr=(g+1) mod NUM_REQ.
  - Transfer with last=0: stay in LOCK and clear the stall counter.
- Watchdog (LOCK only):
  - The stall counter increments on each cycle with req_valid[g]=0 and clears on each cycle with req_valid[g]=1.
  - When the counter reaches STALL_TIMEOUT: pulse stall_err for 1 cycle, set stall_id=g, go to IDLE, set rr_ptr=(g+1) mod NUM_REQ, clear the counter.
  - If the owner is valid but the sink is not ready, the counter stays at 0; backpressure is never a stall.
- IDLE always takes one cycle; back-to-back packets from different requesters have exactly one bubble cycle between them.
- A single-byte packet (last=1 on the first byte) holds the lock for exactly one transfer.
- If the owner asserts valid on the same cycle the watchdog expires, the expiry wins: no transfer, req_ready[g]=0 that cycle.
- Requesters must keep valid/data/last stable until accepted; the arbiter does not check this.
- Width rules:
  - rr_ptr and stall_id are $clog2(NUM_REQ) bits; wrap is explicit modulo, not natural overflow, because NUM_REQ need not be a power of 2.
  - The stall counter is 16 bits and saturates.
- Reset mid-packet drops the lock immediately. The partial packet is lost, and uart_tx is reset from the same source.

Decomposition:
- Package uart_pkg: the arb_state_e enum {IDLE, LOCK}; the DATA_W default constant; a function returning the round-robin next index.
- Sub-module rr_pick: combinational priority picker; inputs req vector and start pointer; outputs one-hot and index. It is reusable by later arbiters.

Test Plan:
- Single requester: req0 sends bytes 0x41, 0x42, 0x43 (last on 0x43) with byte_out_ready=1 -> grant=0001 one cycle after valid. byte_out carries 41, 42, 43 on consecutive cycles, then grant=0.
- Round-robin: all 4 requesters valid with 1-byte packets 0xA0..0xA3 -> output order A0, A1, A2, A3 with one idle cycle between each. Repeating the run keeps the same order (rr_ptr wraps 3->0).
- Packet lock: req1 sends a 3-byte packet while req0 and req2 stay valid throughout -> no interleaving. The next grant goes to req2, not req0.
- Backpressure: byte_out_ready=0 for 5000 cycles while req0 holds valid mid-packet -> no stall_err. The byte is accepted when ready returns, with data unchanged.
- Stall: STALL_TIMEOUT=10; req3 sends one byte without last, then drops valid -> stall_err pulses exactly 10 cycles later, stall_id=3, grant=0. A waiting req0 is granted on the next cycle.
- Async reset: assert rst_n=0 mid-packet between clock edges -> grant, req_ready and byte_out_valid go to 0 without waiting for a clock edge. After release, arbitration restarts from req0.
